// File: rtl/spi_transaction_controller.sv
// -----------------------------------------------------------------------------
// spi_transaction_controller
//
// Two-requester SPI master sequencer. It owns one external spi_clock_generator
// through gen_reset and one MOSI/MISO bus, and gives each requester its own
// chip select. Frames are DATA_W bits long, SPI mode 0, MSB first. The
// generator's high_t/low_t ticks are the bit strobes: MISO is sampled on
// high_t and MOSI advances on low_t. Requesters are served round-robin.
//
// Ports
//   clock              system clock, all logic on posedge
//   reset              synchronous active-low reset
//   req0/req1          frame request, held high until the matching done pulse
//   tx_data0/tx_data1  frame to send, sampled only on the grant edge
//   done0/done1        one-clock completion pulse, rx_data valid with it
//   rx_data            last received frame, held between frames
//   busy               frame in progress (grant+1 until completion)
//   gen_reset          to the clock generator, 1 holds sclk low
//   high_t/low_t       generator rising/falling-edge ticks
//   miso/mosi          serial data in/out
//   cs0_n/cs1_n        active-low chip selects for requester 0/1
// -----------------------------------------------------------------------------
module spi_transaction_controller #(
  parameter int DATA_W   = 8,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic [DATA_W-1:0] tx_data0,
  output logic              done0,
  input  logic              req1,
  input  logic [DATA_W-1:0] tx_data1,
  output logic              done1,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              gen_reset,
  input  logic              high_t,
  input  logic              low_t,
  input  logic              miso,
  output logic              mosi,
  output logic              cs0_n,
  output logic              cs1_n
);

  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BC_W    = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BC_W-1:0]   bit_cnt_q;
  logic [DATA_W-1:0] tx_sh_q;
  logic [DATA_W-1:0] rx_sh_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              gnt_q;        // requester owning the current frame
  logic              last_grant_q; // requester served by the previous frame
  logic              cs0_n_q, cs1_n_q, gen_reset_q, mosi_q, busy_q;
  logic              done0_q, done1_q;

  // Arbitration result for a grant taken this cycle; only used in IDLE.
  logic              grant_d;
  logic [DATA_W-1:0] tx_pick_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    grant_d = 1'b0;
    if (req0 && req1) begin
      grant_d = ~last_grant_q;
    end else if (req1) begin
      grant_d = 1'b1;
    end
    tx_pick_d = grant_d ? tx_data1 : tx_data0;
  end

  // NOTE: all state is updated with non-blocking assignments so every branch
  // sees the pre-edge value of every register, whatever the statement order.
  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous, so it is an ordinary branch sampled at the
    // edge; a mid-frame reset simply overrides the frame at that edge.
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      tx_sh_q      <= '0;
      rx_sh_q      <= '0;
      rx_data_q    <= '0;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      cs0_n_q      <= 1'b1;
      cs1_n_q      <= 1'b1;
      gen_reset_q  <= 1'b1;
      mosi_q       <= 1'b0;
      busy_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
    end else begin
      // done is a pulse: cleared every cycle unless HOLD finishes below.
      done0_q <= 1'b0;
      done1_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            gnt_q     <= grant_d;
            tx_sh_q   <= tx_pick_d;
            mosi_q    <= tx_pick_d[DATA_W-1];
            cs0_n_q   <= grant_d;
            cs1_n_q   <= ~grant_d;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
            cnt_q     <= CNT_W'(CS_SETUP - 1);
            state_q   <= SETUP;
          end
        end

        SETUP: begin
          if (cnt_q == '0) begin
            gen_reset_q <= 1'b0;
            state_q     <= SHIFT;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        SHIFT: begin
          // A coincident low_t is dropped: high_t takes priority.
          if (high_t) begin
            rx_sh_q   <= {rx_sh_q[DATA_W-2:0], miso};
            bit_cnt_q <= bit_cnt_q + BC_W'(1);
          end else if (low_t) begin
            if (bit_cnt_q == BC_W'(DATA_W)) begin
              // Falling edge after the last sampled bit ends the frame.
              gen_reset_q <= 1'b1;
              mosi_q      <= 1'b0;
              cnt_q       <= CNT_W'(CS_HOLD - 1);
              state_q     <= HOLD;
            end else begin
              tx_sh_q <= tx_sh_q << 1;
              mosi_q  <= tx_sh_q[DATA_W-2];
            end
          end
        end

        HOLD: begin
          if (cnt_q == '0) begin
            cs0_n_q      <= 1'b1;
            cs1_n_q      <= 1'b1;
            rx_data_q    <= rx_sh_q;
            done0_q      <= ~gnt_q;
            done1_q      <= gnt_q;
            busy_q       <= 1'b0;
            last_grant_q <= gnt_q;
            state_q      <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign done0     = done0_q;
  assign done1     = done1_q;
  assign rx_data   = rx_data_q;
  assign busy      = busy_q;
  assign gen_reset = gen_reset_q;
  assign mosi      = mosi_q;
  assign cs0_n     = cs0_n_q;
  assign cs1_n     = cs1_n_q;

endmodule
